// File: rtl/wall_pkg.sv
// Shared state codes, colours and coordinate widths for the wall datapath.
package wall_pkg;

  localparam int XW = 8;
  localparam int YW = 7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_WAIT   = 3'd1;
  localparam state_t ST_ERASE  = 3'd2;
  localparam state_t ST_UPDATE = 3'd3;
  localparam state_t ST_DRAW   = 3'd4;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WALL  = 3'b111;

  // True when lo <= v < lo+len, evaluated wide enough that nothing wraps.
  function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                   input logic [9:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/wall_scan.sv
// Column-inner / row-outer pixel counter shared by the erase and draw scans.
module wall_scan
  import wall_pkg::*;
#(
  parameter int WALL_W   = 4,
  parameter int SCREEN_H = 120
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          en,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          last
);

  logic col_end;

  assign col_end = (col == XW'(WALL_W - 1));
  assign last    = col_end && (row == YW'(SCREEN_H - 1));

  // Counters wrap to zero after the last pixel so the next scan starts clean.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + YW'(1);
      end else begin
        col <= col + XW'(1);
      end
    end
  end

endmodule

// File: rtl/wall_datapath.sv
// Wall position, frame pacing and erase/step/redraw pixel generation.
// Optional feature: define PLAYER_HIT_EN to end the run on a player collision.
module wall_datapath
  import wall_pkg::*;
#(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int WALL_W    = 4,
  parameter int GAP_H     = 30,
  parameter int START_X   = 156,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 833334,
  parameter int PLAYER_W  = 4,
  parameter int PLAYER_H  = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          move,
  input  logic [YW-1:0] gap_y,
  input  logic [XW-1:0] player_x,
  input  logic [YW-1:0] player_y,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          touched
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  state_t        state, state_nx;
  logic [XW-1:0] wall_x, new_x;
  logic [YW-1:0] gap;
  logic [FW-1:0] frame_cnt;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          last, scanning, edge_hit, hit, end_run;
  logic [XW:0]   pix_x;
  logic          in_gap;

  assign scanning = (state == ST_ERASE) || (state == ST_DRAW);
  assign new_x    = wall_x - XW'(STEP);
  assign edge_hit = (wall_x < XW'(STEP));
  assign end_run  = edge_hit || hit;
  assign pix_x    = {1'b0, wall_x} + {1'b0, col};
  assign in_gap   = in_span(10'(row), 10'(gap), 10'(GAP_H));

`ifdef PLAYER_HIT_EN
  logic [9:0] nx, px, py, gp;
  assign nx  = 10'(new_x);
  assign px  = 10'(player_x);
  assign py  = 10'(player_y);
  assign gp  = 10'(gap);
  // Overlap with the stepped column, but only where the player is not fully inside the gap.
  assign hit = (px < nx + 10'(WALL_W)) && (px + 10'(PLAYER_W) > nx) &&
               ((py < gp) || (py + 10'(PLAYER_H) > gp + 10'(GAP_H)));
`else
  logic unused_player;
  assign unused_player = ^{player_x, player_y, 10'(PLAYER_W), 10'(PLAYER_H)};
  assign hit = 1'b0;
`endif

  wall_scan #(
    .WALL_W  (WALL_W),
    .SCREEN_H(SCREEN_H)
  ) u_scan (
    .clk   (clk),
    .resetn(resetn),
    .clear (start),
    .en    (scanning),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  // Next-state selection; start overrides everything.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (move) state_nx = ST_WAIT; else state_nx = ST_IDLE;
      ST_WAIT: begin
        if (!move) state_nx = ST_IDLE;
        else if (frame_cnt == '0) state_nx = ST_ERASE;
        else state_nx = ST_WAIT;
      end
      ST_ERASE:  if (last) state_nx = ST_UPDATE; else state_nx = ST_ERASE;
      ST_UPDATE: if (end_run) state_nx = ST_IDLE; else state_nx = ST_DRAW;
      ST_DRAW: begin
        if (last) state_nx = move ? ST_WAIT : ST_IDLE;
        else state_nx = ST_DRAW;
      end
      default:   state_nx = ST_IDLE;
    endcase
    if (start) state_nx = ST_IDLE;
    else state_nx = state_nx;
  end

  // State, wall position, latched gap and frame pacing counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      wall_x    <= XW'(START_X);
      gap       <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        wall_x    <= XW'(START_X);
        gap       <= gap_y;
        frame_cnt <= '0;
      end else begin
        if ((state == ST_UPDATE) && !edge_hit) wall_x <= new_x;
        if ((state_nx == ST_WAIT) && (state != ST_WAIT)) frame_cnt <= FW'(FRAME_DIV - 1);
        else if ((state == ST_WAIT) && (frame_cnt != '0)) frame_cnt <= frame_cnt - FW'(1);
      end
    end
  end

  // Registered pixel port: one pixel per scan cycle, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_out   <= '0;
      y_out   <= '0;
      colour  <= COL_BLACK;
      plot    <= 1'b0;
      touched <= 1'b0;
    end else if (start) begin
      plot    <= 1'b0;
      touched <= 1'b0;
    end else begin
      touched <= (state == ST_UPDATE) && end_run;
      if (scanning) begin
        x_out  <= pix_x[XW-1:0];
        y_out  <= row;
        colour <= (state == ST_DRAW) ? COL_WALL : COL_BLACK;
        plot   <= (pix_x < (XW+1)'(SCREEN_W)) && !((state == ST_DRAW) && in_gap);
      end else begin
        plot <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wall_datapath.sv
// Self-checking bench for wall_datapath: frame-level model plus an edge-column instance.
module tb_wall_datapath;

  localparam int FD = 4, SH = 8, WW = 2, SX = 3, ST = 1, GH = 2, SW = 160, PW = 4, PH = 4;

  logic       clk = 1'b0;
  logic       resetn, start, move;
  logic [6:0] gap_y, player_y;
  logic [7:0] player_x;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, touched;

  logic       e_start, e_move;
  logic [6:0] e_gap;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_col;
  logic       e_plot, e_touched;

  always #5 clk = ~clk;

  wall_datapath #(.SCREEN_W(SW), .SCREEN_H(SH), .WALL_W(WW), .GAP_H(GH), .START_X(SX),
                  .STEP(ST), .FRAME_DIV(FD), .PLAYER_W(PW), .PLAYER_H(PH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .move(move), .gap_y(gap_y),
    .player_x(player_x), .player_y(player_y), .x_out(x_out), .y_out(y_out),
    .colour(colour), .plot(plot), .touched(touched));

  wall_datapath #(.SCREEN_W(SW), .SCREEN_H(SH), .WALL_W(WW), .GAP_H(GH), .START_X(159),
                  .STEP(ST), .FRAME_DIV(FD), .PLAYER_W(PW), .PLAYER_H(PH)) u_edge (
    .clk(clk), .resetn(resetn), .start(e_start), .move(e_move), .gap_y(e_gap),
    .player_x(player_x), .player_y(player_y), .x_out(e_x), .y_out(e_y),
    .colour(e_col), .plot(e_plot), .touched(e_touched));

  typedef struct {
    bit       plot;
    bit [7:0] x;
    bit [6:0] y;
    bit [2:0] c;
    bit       t;
  } exp_t;

  exp_t exp_q[$];
  exp_t plan[$];
  int   checks = 0, failures = 0;
  int   m_x, m_gap;
  int   dut_plots, dut_touch;
  int   e_erase, e_draw, e_bad, e_draw_ok, e_touch;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Player collision rule, applied only when the feature is built in.
  function automatic bit model_hit(input int nx);
`ifdef PLAYER_HIT_EN
    int px, py;
    px = int'(player_x);
    py = int'(player_y);
    return (px < nx + WW) && (px + PW > nx) && ((py < m_gap) || (py + PH > m_gap + GH));
`else
    return (nx < 0);
`endif
  endfunction

  task automatic push_quiet(input bit t);
    exp_t e;
    e.plot = 1'b0; e.x = 8'd0; e.y = 7'd0; e.c = 3'd0; e.t = t;
    plan.push_back(e);
  endtask

  task automatic push_scan(input bit draw);
    exp_t e;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < WW; c++) begin
        e.x    = 8'(m_x + c);
        e.y    = 7'(r);
        e.c    = draw ? 3'd7 : 3'd0;
        e.t    = 1'b0;
        e.plot = (m_x + c < SW) && !(draw && r >= m_gap && r < m_gap + GH);
        plan.push_back(e);
      end
    end
  endtask

  // Expected output stream for n frames; ends early when the run is ended.
  task automatic gen_frames(input int n, input bit from_idle);
    plan.delete();
    if (from_idle) push_quiet(1'b0);
    for (int f = 0; f < n; f++) begin
      repeat (FD) push_quiet(1'b0);
      push_scan(1'b0);
      if (m_x < ST) begin
        push_quiet(1'b1);
        return;
      end
      m_x = m_x - ST;
      if (model_hit(m_x)) begin
        push_quiet(1'b1);
        return;
      end
      push_quiet(1'b0);
      push_scan(1'b1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_plan(input int upto);
    for (int i = 0; i < upto; i++) exp_q.push_back(plan[i]);
    repeat (upto) tick();
  endtask

  task automatic do_start(input int g);
    exp_t e;
    e.plot = 1'b0; e.x = 8'd0; e.y = 7'd0; e.c = 3'd0; e.t = 1'b0;
    start = 1'b1; move = 1'b0; gap_y = 7'(g);
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    m_x = SX;
    m_gap = g;
  endtask

  task automatic settle(input int n);
    move = 1'b0;
    plan.delete();
    repeat (n) push_quiet(1'b0);
    run_plan(n);
  endtask

  function automatic int plan_plots();
    int k = 0;
    foreach (plan[i]) if (plan[i].plot) k++;
    return k;
  endfunction

  // Cycle-by-cycle comparison of the main instance against the expected stream.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (plot !== e.plot || touched !== e.t ||
          (e.plot && (x_out !== e.x || y_out !== e.y || colour !== e.c))) begin
        failures++;
        $display("FAIL pixel @%0t: got plot=%0b x=%0d y=%0d col=%0d touched=%0b, expected plot=%0b x=%0d y=%0d col=%0d touched=%0b",
                 $time, plot, x_out, y_out, colour, touched, e.plot, e.x, e.y, e.c, e.t);
      end
      if (plot === 1'b1) dut_plots++;
      if (touched === 1'b1) dut_touch++;
    end
  end

  // Tallies for the right-edge instance.
  always @(negedge clk) begin
    if (e_plot === 1'b1) begin
      if (e_col == 3'd0) e_erase++;
      if (e_col == 3'd7) e_draw++;
      if (e_x >= 8'd160) e_bad++;
      if (e_col == 3'd7 && (e_x == 8'd158 || e_x == 8'd159)) e_draw_ok++;
    end
    if (e_touched === 1'b1) e_touch++;
  end

  initial begin
    resetn = 1'b0; start = 1'b0; move = 1'b0; gap_y = 7'd0;
    e_start = 1'b0; e_move = 1'b0; e_gap = 7'd0;
`ifdef PLAYER_HIT_EN
    player_x = 8'd200; player_y = 7'd0;
`else
    player_x = 8'd2; player_y = 7'd0;
`endif
    repeat (3) tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_idle", int'({x_out, y_out, colour, plot, touched}), 0);
    end

    // One frame from START_X with gap at rows 3..4.
    do_start(3);
    move = 1'b1;
    gen_frames(1, 1'b1);
    chk("model_len_1frame", plan.size(), 38);
    chk("model_plots_1frame", plan_plots(), 28);
    chk("model_first_erase", int'({plan[5].plot, plan[5].x, plan[5].y, plan[5].c}), int'({1'b1, 8'd3, 7'd0, 3'd0}));
    chk("model_first_draw", int'({plan[22].plot, plan[22].x, plan[22].y, plan[22].c}), int'({1'b1, 8'd2, 7'd0, 3'd7}));
    dut_plots = 0;
    run_plan(plan.size());
    settle(3);
    chk("plots_1frame", dut_plots, 28);

    // Four frames: walls at 2,1,0 then the left edge ends the run.
    do_start(3);
    move = 1'b1;
    gen_frames(4, 1'b1);
    chk("model_len_4frame", plan.size(), 133);
    chk("model_plots_4frame", plan_plots(), 100);
    chk("model_touch_last", int'(plan[plan.size()-1].t), 1);
    dut_plots = 0; dut_touch = 0;
    run_plan(plan.size());
    settle(4);
    chk("plots_4frame", dut_plots, 100);
    chk("touch_4frame", dut_touch, 1);

    // Abort during DRAW, then verify the wall restarted at START_X.
    do_start(3);
    move = 1'b1;
    gen_frames(1, 1'b1);
    chk("model_mid_draw_pixel", int'({plan[26].plot, plan[26].x, plan[26].y}), int'({1'b1, 8'd2, 7'd2}));
    run_plan(27);
    do_start(0);
    settle(3);
    move = 1'b1;
    gen_frames(1, 1'b1);
    dut_plots = 0;
    run_plan(plan.size());
    settle(3);
    chk("plots_after_abort", dut_plots, 28);

    // Player at (2,0) with gap at 5.
    do_start(5);
    player_x = 8'd2; player_y = 7'd0;
    move = 1'b1;
    gen_frames(1, 1'b1);
    dut_plots = 0; dut_touch = 0;
    run_plan(plan.size());
    settle(4);
`ifdef PLAYER_HIT_EN
    chk("hit_touch", dut_touch, 1);
    chk("hit_plots", dut_plots, 16);
`else
    chk("hit_touch", dut_touch, 0);
    chk("hit_plots", dut_plots, 28);
`endif

    // Player clear of the column never ends the run.
    do_start(5);
    player_x = 8'd100; player_y = 7'd0;
    move = 1'b1;
    gen_frames(1, 1'b1);
    dut_touch = 0;
    run_plan(plan.size());
    settle(3);
    chk("far_player_touch", dut_touch, 0);

    // Right-edge instance: START_X=159 clips x=160.
    e_erase = 0; e_draw = 0; e_bad = 0; e_draw_ok = 0; e_touch = 0;
    e_start = 1'b1; e_gap = 7'd100;
    tick();
    e_start = 1'b0; e_move = 1'b1;
    repeat (1 + FD + 2*WW*SH + 1) tick();
    e_move = 1'b0;
    repeat (3) tick();
    chk("edge_erase_plots", e_erase, 8);
    chk("edge_draw_plots", e_draw, 16);
    chk("edge_draw_cols", e_draw_ok, 16);
    chk("edge_clip", e_bad, 0);
    chk("edge_touch", e_touch, 0);

    repeat (2) tick();
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
